huffman_decoder: RTL

Bit-serial canonical Huffman decoder: the receive-side counterpart of the team's Huffman encoder. A host loads a canonical code description, meaning the number of codes per length plus the symbols in canonical order. The block derives the per-length first-code and offset tables, then consumes a bitstream one bit per handshake and emits one decoded symbol per completed codeword. It sits between the bitstream source and the symbol consumer, with valid/ready handshakes on both sides.

---
 rtl/huffman_pkg.sv | 18 +
 rtl/huffman_decoder_canon_table.sv | 106 ++++++++++
 rtl/huffman_decoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared types and default sizing for the canonical Huffman decoder.
package huffman_pkg;

  localparam int unsigned DEF_SYM_WIDTH = 8;
  localparam int unsigned DEF_MAX_LEN   = 16;
  localparam int unsigned DEF_NUM_SYMS  = 256;
  localparam int unsigned DEF_AW        = $clog2(DEF_NUM_SYMS);
  localparam int unsigned DEF_CW        = DEF_AW + 1;
  localparam int unsigned DEF_LW        = $clog2(DEF_MAX_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUILD  = 2'd1,
    ST_DECODE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

endpackage

// File: rtl/huffman_decoder_canon_table.sv
// Canonical code tables: per-length counts, derived first-code/offset
// tables, symbol storage and the combinational (code, len) lookup.
module huffman_canon_table
  import huffman_pkg::*;
#(
  parameter int unsigned SYM_WIDTH = DEF_SYM_WIDTH,
  parameter int unsigned MAX_LEN   = DEF_MAX_LEN,
  parameter int unsigned NUM_SYMS  = DEF_NUM_SYMS,
  parameter int unsigned AW        = $clog2(NUM_SYMS),
  parameter int unsigned CW        = AW + 1,
  parameter int unsigned LW        = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 cnt_we,
  input  logic [LW-1:0]        cnt_len,
  input  logic [CW-1:0]        cnt_val,
  input  logic                 sym_we,
  input  logic [AW-1:0]        sym_addr,
  input  logic [SYM_WIDTH-1:0] sym_data,
  input  logic                 build_go,
  output logic                 build_last_c,
  input  logic [MAX_LEN-1:0]   lk_code,
  input  logic [LW-1:0]        lk_len,
  output logic                 lk_match_c,
  output logic [SYM_WIDTH-1:0] lk_sym_c
);

  localparam int unsigned FW = MAX_LEN + 1;

  // Entry 0 of each table is never written and stays zero, so the BUILD
  // step for length 1 can read index 0 like any other length.
  logic [CW-1:0]        count_q  [MAX_LEN+1];
  logic [FW-1:0]        first_q  [MAX_LEN+1];
  logic [FW-1:0]        offset_q [MAX_LEN+1];
  logic [SYM_WIDTH-1:0] sym_mem  [NUM_SYMS];

  logic [LW-1:0] build_l;
  logic          build_act;
  logic [LW-1:0] prev_l_c;
  logic [FW-1:0] first_nx_c;
  logic [FW-1:0] offset_nx_c;
  logic [FW-1:0] diff_c;
  logic [AW-1:0] idx_c;
  logic          len_ok_c;
  logic          cnt_ok_c;

  assign cnt_ok_c     = wr_en && cnt_we && (cnt_len != '0) && (32'(cnt_len) <= MAX_LEN);
  assign build_last_c = build_act && (32'(build_l) == MAX_LEN);

  // Host writes of per-length code counts; length 0 and out-of-range ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= int'(MAX_LEN); i++) count_q[i] <= '0;
    end else if (cnt_ok_c) begin
      count_q[cnt_len] <= cnt_val;
    end
  end

  // Symbol storage in canonical rank order; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && sym_we) sym_mem[sym_addr] <= sym_data;
  end

  // Recurrence for the current BUILD length from the previous length's entries.
  always_comb begin
    prev_l_c    = build_l - LW'(1);
    first_nx_c  = (first_q[prev_l_c] + FW'(count_q[prev_l_c])) << 1;
    offset_nx_c = offset_q[prev_l_c] + FW'(count_q[prev_l_c]);
  end

  // BUILD iterator: one length per cycle, 1..MAX_LEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      build_act <= 1'b0;
      build_l   <= '0;
      for (int i = 0; i <= int'(MAX_LEN); i++) begin
        first_q[i]  <= '0;
        offset_q[i] <= '0;
      end
    end else if (build_go) begin
      build_act <= 1'b1;
      build_l   <= LW'(1);
    end else if (build_act) begin
      first_q[build_l]  <= first_nx_c;
      offset_q[build_l] <= offset_nx_c;
      if (build_last_c) begin
        build_act <= 1'b0;
      end else begin
        build_l <= build_l + LW'(1);
      end
    end
  end

  // Codeword lookup: in range of this length's codes, and its symbol index.
  always_comb begin
    len_ok_c   = (lk_len != '0) && (32'(lk_len) <= MAX_LEN);
    diff_c     = FW'(lk_code) - first_q[lk_len];
    idx_c      = AW'(offset_q[lk_len] + diff_c);
    lk_match_c = len_ok_c && (diff_c < FW'(count_q[lk_len]));
  end

  assign lk_sym_c = sym_mem[idx_c];

endmodule

// File: rtl/huffman_decoder.sv
// Bit-serial canonical Huffman decoder: control FSM, codeword accumulator
// and the bit/symbol valid-ready handshakes around the canonical tables.
module huffman_decoder
  import huffman_pkg::*;
#(
  parameter int unsigned SYM_WIDTH = DEF_SYM_WIDTH,
  parameter int unsigned MAX_LEN   = DEF_MAX_LEN,
  parameter int unsigned NUM_SYMS  = DEF_NUM_SYMS,
  parameter int unsigned AW        = $clog2(NUM_SYMS),
  parameter int unsigned CW        = AW + 1,
  parameter int unsigned LW        = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cnt_we,
  input  logic [LW-1:0]        cnt_len,
  input  logic [CW-1:0]        cnt_val,
  input  logic                 sym_we,
  input  logic [AW-1:0]        sym_addr,
  input  logic [SYM_WIDTH-1:0] sym_data,
  input  logic                 start,
  input  logic                 flush,
  output logic                 busy,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic [SYM_WIDTH-1:0] sym_out,
  output logic                 sym_valid,
  input  logic                 sym_ready,
  output logic                 err
);

  state_t state, state_nx;

  // The accumulator only ever holds an unfinished codeword, so at most
  // MAX_LEN-1 bits; the candidate adds the incoming bit.
  logic [MAX_LEN-2:0]   code_q, code_nx;
  logic [LW-1:0]        len_q, len_nx;
  logic [SYM_WIDTH-1:0] sym_out_nx;
  logic                 sym_valid_nx;
  logic                 err_nx;

  logic                 build_go_c;
  logic                 build_last_c;
  logic                 tbl_wr_en_c;
  logic                 bit_hs_c;
  logic [MAX_LEN-1:0]   cand_code_c;
  logic [LW-1:0]        cand_len_c;
  logic                 lk_match_c;
  logic [SYM_WIDTH-1:0] lk_sym_c;

  assign cand_code_c = {code_q, bit_in};
  assign cand_len_c  = len_q + LW'(1);

  huffman_canon_table #(
    .SYM_WIDTH (SYM_WIDTH),
    .MAX_LEN   (MAX_LEN),
    .NUM_SYMS  (NUM_SYMS),
    .AW        (AW),
    .CW        (CW),
    .LW        (LW)
  ) u_table (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (tbl_wr_en_c),
    .cnt_we       (cnt_we),
    .cnt_len      (cnt_len),
    .cnt_val      (cnt_val),
    .sym_we       (sym_we),
    .sym_addr     (sym_addr),
    .sym_data     (sym_data),
    .build_go     (build_go_c),
    .build_last_c (build_last_c),
    .lk_code      (cand_code_c),
    .lk_len       (cand_len_c),
    .lk_match_c   (lk_match_c),
    .lk_sym_c     (lk_sym_c)
  );

  // Next-state, accumulator and output-register updates.
  always_comb begin
    state_nx     = state;
    code_nx      = code_q;
    len_nx       = len_q;
    sym_out_nx   = sym_out;
    sym_valid_nx = sym_valid && !sym_ready;
    err_nx       = err;
    build_go_c   = 1'b0;
    tbl_wr_en_c  = (state == ST_IDLE) || (state == ST_ERROR);
    // A flush in the same cycle discards the offered bit.
    bit_hs_c     = bit_valid && bit_ready && !flush;

    case (state)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          state_nx   = ST_BUILD;
          build_go_c = 1'b1;
          err_nx     = 1'b0;
          code_nx    = '0;
          len_nx     = '0;
        end
      end
      ST_BUILD: begin
        if (build_last_c) state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        if (bit_hs_c) begin
          if (lk_match_c) begin
            sym_out_nx   = lk_sym_c;
            sym_valid_nx = 1'b1;
            code_nx      = '0;
            len_nx       = '0;
          end else if (32'(cand_len_c) == MAX_LEN) begin
            state_nx = ST_ERROR;
            err_nx   = 1'b1;
            code_nx  = '0;
            len_nx   = '0;
          end else begin
            code_nx = cand_code_c[MAX_LEN-2:0];
            len_nx  = cand_len_c;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (flush) begin
      code_nx = '0;
      len_nx  = '0;
    end
  end

  // State and output registers; busy/bit_ready follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      code_q    <= '0;
      len_q     <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      bit_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      code_q    <= code_nx;
      len_q     <= len_nx;
      sym_out   <= sym_out_nx;
      sym_valid <= sym_valid_nx;
      err       <= err_nx;
      busy      <= (state_nx == ST_BUILD);
      bit_ready <= (state_nx == ST_DECODE) && !sym_valid_nx;
    end
  end

endmodule
